// File: rtl/data_bus_pkg.sv
// data_bus_pkg: shared state encoding and default address map for the data bus master.
package data_bus_pkg;
  typedef enum logic [1:0] {IDLE, BUS, ERR} state_e;
  localparam int unsigned ERR_DATA = 0;
  localparam logic [127:0] DEF_BASE = {32'h0003_0000, 32'h0002_0000, 32'h0001_0000, 32'h0000_0000};
  localparam logic [127:0] DEF_MASK = {4{32'hFFFF_0000}};
endpackage

// File: rtl/data_bus_decode.sv
// data_bus_decode: address to one-hot slave select, lowest matching index wins.
module data_bus_decode
  import data_bus_pkg::*;
#(
  parameter int NUM_SLAVES = 4,
  parameter int ADDR_W = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE = DEF_BASE,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK = DEF_MASK
) (
  input  logic [ADDR_W-1:0]     addr_i,
  output logic [NUM_SLAVES-1:0] hit_o,
  output logic                  any_o
);
  logic [NUM_SLAVES-1:0] raw;
  for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_hit
    assign raw[i] = (addr_i & SLAVE_MASK[i*ADDR_W +: ADDR_W]) == SLAVE_BASE[i*ADDR_W +: ADDR_W];
  end
  // isolate the lowest set bit so overlapping regions resolve by priority
  assign hit_o = raw & (~raw + NUM_SLAVES'(1));
  assign any_o = |raw;
endmodule

// File: rtl/data_bus_wb.sv
// data_bus_wb: single-beat Wishbone master with address decode for the CPU data port.
// Optional ACK timeout abort enabled by defining DATA_BUS_TIMEOUT_EN.
module data_bus_wb
  import data_bus_pkg::*;
#(
`ifdef DATA_BUS_TIMEOUT_EN
  parameter int TIMEOUT = 16,
`endif
  parameter int NUM_SLAVES = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE = DEF_BASE,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK = DEF_MASK
) (
  input  logic                         I_clk,
  input  logic                         I_rst,
  input  logic                         I_req,
  input  logic                         I_memrw,
  input  logic [ADDR_W-1:0]            I_address,
  input  logic [DATA_W-1:0]            I_data,
  output logic [DATA_W-1:0]            O_data,
  output logic                         O_done,
  output logic                         O_err,
  output logic                         O_busy,
  output logic                         O_cyc,
  output logic [NUM_SLAVES-1:0]        O_stb,
  output logic                         O_we,
  output logic [ADDR_W-1:0]            O_adr,
  output logic [DATA_W-1:0]            O_dat,
  input  logic [NUM_SLAVES*DATA_W-1:0] I_dat,
  input  logic [NUM_SLAVES-1:0]        I_ack
);
  state_e state_q, state_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [DATA_W-1:0] dat_q, dat_d, data_q, data_d, rdata;
  logic [NUM_SLAVES-1:0] stb_q, stb_d, hit;
  logic we_q, we_d, cyc_q, cyc_d, done_q, done_d, err_q, err_d, any, ack;
`ifdef DATA_BUS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
`endif
  data_bus_decode #(
    .NUM_SLAVES(NUM_SLAVES), .ADDR_W(ADDR_W), .SLAVE_BASE(SLAVE_BASE), .SLAVE_MASK(SLAVE_MASK)
  ) u_decode (.addr_i(I_address), .hit_o(hit), .any_o(any));
  assign ack = |(I_ack & stb_q);
  always_comb begin
    rdata = '0;
    for (int k = 0; k < NUM_SLAVES; k++) rdata = rdata | (stb_q[k] ? I_dat[k*DATA_W +: DATA_W] : '0);
  end
  always_comb begin
    state_d = state_q;
    adr_d = adr_q;
    dat_d = dat_q;
    we_d = we_q;
    stb_d = stb_q;
    cyc_d = cyc_q;
    data_d = data_q;
    done_d = 1'b0;
    err_d = 1'b0;
`ifdef DATA_BUS_TIMEOUT_EN
    cnt_d = cnt_q;
`endif
    case (state_q)
      IDLE: if (I_req) begin
        adr_d = I_address;
        dat_d = I_data;
        we_d = I_memrw;
        stb_d = hit;
        cyc_d = any;
        state_d = any ? BUS : ERR;
`ifdef DATA_BUS_TIMEOUT_EN
        cnt_d = '0;
`endif
      end
      BUS: begin
        if (ack) begin
          state_d = IDLE;
          stb_d = '0;
          cyc_d = 1'b0;
          done_d = 1'b1;
          data_d = we_q ? data_q : rdata;
        end
`ifdef DATA_BUS_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d = IDLE;
          stb_d = '0;
          cyc_d = 1'b0;
          done_d = 1'b1;
          err_d = 1'b1;
          data_d = DATA_W'(ERR_DATA);
        end else cnt_d = cnt_q + CW'(1);
`endif
      end
      ERR: begin
        state_d = IDLE;
        done_d = 1'b1;
        err_d = 1'b1;
        data_d = DATA_W'(ERR_DATA);
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_q <= IDLE;
      adr_q <= '0;
      dat_q <= '0;
      we_q <= 1'b0;
      stb_q <= '0;
      cyc_q <= 1'b0;
      data_q <= '0;
      done_q <= 1'b0;
      err_q <= 1'b0;
`ifdef DATA_BUS_TIMEOUT_EN
      cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      adr_q <= adr_d;
      dat_q <= dat_d;
      we_q <= we_d;
      stb_q <= stb_d;
      cyc_q <= cyc_d;
      data_q <= data_d;
      done_q <= done_d;
      err_q <= err_d;
`ifdef DATA_BUS_TIMEOUT_EN
      cnt_q <= cnt_d;
`endif
    end
  end
  assign O_data = data_q;
  assign O_done = done_q;
  assign O_err = err_q;
  assign O_busy = cyc_q;
  assign O_cyc = cyc_q;
  assign O_stb = stb_q;
  assign O_we = we_q;
  assign O_adr = adr_q;
  assign O_dat = dat_q;
endmodule

// File: tb/tb_data_bus_wb.sv
// tb_data_bus_wb: scoreboard bench for data_bus_wb; completions are checked against queued expectations.
module tb_data_bus_wb;
  logic clk = 1'b0, rst = 1'b1, req = 1'b0, memrw = 1'b0;
  logic [31:0] address = '0, data = '0, o_data, o_adr, o_dat;
  logic o_done, o_err, o_busy, o_cyc, o_we;
  logic [3:0] o_stb, ack = '0;
  logic [127:0] sdat = '0;
  logic [32:0] exp_q[$];
  logic [31:0] model_data = '0;
  int n_chk = 0, n_err = 0, n_done = 0, n_push = 0;

  always #5 clk = ~clk;

  data_bus_wb dut (
    .I_clk(clk), .I_rst(rst), .I_req(req), .I_memrw(memrw), .I_address(address), .I_data(data),
    .O_data(o_data), .O_done(o_done), .O_err(o_err), .O_busy(o_busy), .O_cyc(o_cyc), .O_stb(o_stb),
    .O_we(o_we), .O_adr(o_adr), .O_dat(o_dat), .I_dat(sdat), .I_ack(ack)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (o_done) begin
      n_done++;
      if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        chk("done_data", o_data, e[32:1]);
        chk("done_err", o_err, e[0]);
      end
    end else if (o_err) chk("err_without_done", o_err, 0);
  end

  task automatic push_exp(input logic [31:0] d, input logic e);
    exp_q.push_back({d, e});
    n_push++;
  endtask

  task automatic txn(input logic rw, input logic [31:0] a, input logic [31:0] d,
                     input int s, input int dly, input logic [31:0] rd, input bit noise);
    @(negedge clk);
    req = 1'b1; memrw = rw; address = a; data = d;
    if (s < 0) model_data = '0;
    else if (!rw) model_data = rd;
    push_exp(model_data, s < 0);
    @(negedge clk);
    req = noise;
    if (s < 0) begin
      chk("miss_stb", o_stb, 0);
      chk("miss_cyc", o_cyc, 0);
      req = 1'b0;
    end else begin
      chk("stb", o_stb, 64'(1 << s));
      chk("cyc", o_cyc, 1);
      chk("busy", o_busy, 1);
      chk("we", o_we, rw);
      chk("adr", o_adr, a);
      chk("dat", o_dat, d);
      for (int i = 0; i < dly; i++) begin
        @(negedge clk);
        req = noise ? ~req : 1'b0;
        ack = (noise && s != 2) ? 4'b0100 : 4'b0000;
        chk("stb_hold", o_stb, 64'(1 << s));
      end
      req = 1'b0;
      ack = 4'(1 << s);
      sdat = '0;
      sdat[s*32 +: 32] = rd;
      @(negedge clk);
      ack = '0;
      chk("stb_clear", o_stb, 0);
      chk("busy_clear", o_busy, 0);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_data", o_data, 0);
    chk("rst_done", o_done, 0);
    chk("rst_err", o_err, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_cyc", o_cyc, 0);
    chk("rst_stb", o_stb, 0);
    chk("rst_we", o_we, 0);
    chk("rst_adr", o_adr, 0);
    rst = 1'b0;
    txn(1'b0, 32'h0000_0010, 32'h0, 0, 1, 32'hCAFE_F00D, 1'b0);
    txn(1'b1, 32'h0002_0004, 32'h1234_5678, 2, 0, 32'hDEAD_BEEF, 1'b0);
    txn(1'b0, 32'h00FF_0000, 32'h0, -1, 0, 32'h0, 1'b0);
    txn(1'b1, 32'h0003_0008, 32'h0BAD_F00D, 3, 2, 32'h1111_2222, 1'b0);
    txn(1'b0, 32'h0001_0004, 32'h0, 1, 5, 32'hA5A5_1234, 1'b1);
    for (int i = 0; i < 6; i++) begin
      int s;
      s = $urandom_range(3);
      txn(1'($urandom_range(1)), {14'h0, 2'(s), 16'($urandom)}, $urandom, s,
          $urandom_range(3), $urandom, 1'b0);
    end
    // abort a pending read with reset; the late ACK must not complete anything
    @(negedge clk);
    req = 1'b1; memrw = 1'b0; address = 32'h0000_0020;
    @(negedge clk);
    req = 1'b0;
    chk("pre_rst_stb", o_stb, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_stb", o_stb, 0);
    chk("mid_rst_cyc", o_cyc, 0);
    chk("mid_rst_busy", o_busy, 0);
    chk("mid_rst_data", o_data, 0);
    chk("mid_rst_adr", o_adr, 0);
    model_data = '0;
    ack = 4'b0001;
    sdat[31:0] = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    ack = '0;
    chk("late_ack_stb", o_stb, 0);
    txn(1'b0, 32'h0000_0040, 32'h0, 0, 1, 32'h5555_AAAA, 1'b0);
`ifdef DATA_BUS_TIMEOUT_EN
    begin
      int hi;
      hi = 0;
      @(negedge clk);
      req = 1'b1; memrw = 1'b0; address = 32'h0003_0000;
      push_exp(32'h0, 1'b1);
      @(negedge clk);
      req = 1'b0;
      for (int i = 0; i < 40; i++) begin
        if (o_stb[3]) hi++;
        @(negedge clk);
      end
      chk("timeout_stb_cycles", 64'(hi), 16);
      chk("timeout_idle_cyc", o_cyc, 0);
    end
`endif
    repeat (4) @(negedge clk);
    chk("pending_expect", 64'(exp_q.size()), 0);
    chk("done_count", 64'(n_done), 64'(n_push));
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
